huff_enc_core: RTL and testbench



---
 rtl/huff_pkg.sv | 37 +++
 rtl/huff_enc_core_if.sv | 17 +
 rtl/huff_enc_core_min2.sv | 47 ++++
 rtl/huff_enc_core.sv | 154 +++++++++++++++
 tb/tb_huff_enc_core.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/huff_pkg.sv
// Shared constants, FSM states and tree node type for the
// three-symbol Huffman encoder.
package huff_pkg;

  localparam int NUM_SYMS = 3;
  localparam int FREQ_W   = 3;
  localparam int SYM_W    = 8;
  localparam int WEIGHT_W = 5;
  localparam int CODE_W   = 3;

  typedef enum logic [2:0] {
    LOAD,
    MERGE1,
    MERGE2,
    ASSIGN,
    EMIT,
    DONE
  } state_e;

  typedef struct packed {
    logic [WEIGHT_W-1:0] weight;
    logic                is_leaf;
    logic [1:0]          idx;
  } node_t;

  // Total order: weight, then leaf before internal, then slot index.
  function automatic logic node_lt(node_t a, node_t b);
    logic w_eq;
    logic k_eq;
    w_eq = (a.weight == b.weight);
    k_eq = (a.is_leaf == b.is_leaf);
    return (a.weight < b.weight)
        || (w_eq && a.is_leaf && !b.is_leaf)
        || (w_eq && k_eq && (a.idx < b.idx));
  endfunction

endpackage

// File: rtl/huff_enc_core_if.sv
// 12-bit pin-limited I/O bus between the pads and the encoder.
interface huff_enc_core_if;

  logic [11:0] io_in;
  logic [11:0] io_out;

  modport master (
    output io_in,
    input  io_out
  );

  modport slave (
    input  io_in,
    output io_out
  );

endinterface

// File: rtl/huff_enc_core_min2.sv
// Picks the two smallest of three leaf nodes (slot index breaks
// ties) and reports their slots, the leftover slot and the sum.
module huff_min2
  import huff_pkg::*;
(
  input  node_t               n0,
  input  node_t               n1,
  input  node_t               n2,
  output logic [1:0]          lo_idx,
  output logic [1:0]          hi_idx,
  output logic [1:0]          rest_idx,
  output logic [WEIGHT_W-1:0] sum_w
);

  logic lt01, lt02, lt12;
  node_t lo, hi;

  function automatic node_t pick(logic [1:0] s,
                                 node_t a, node_t b, node_t c);
    unique case (1'b1)
      s == 2'd0: return a;
      s == 2'd1: return b;
      default:   return c;
    endcase
  endfunction

  always_comb begin
    lt01 = node_lt(n0, n1);
    lt02 = node_lt(n0, n2);
    lt12 = node_lt(n1, n2);
    unique case (1'b1)
      lt01 && lt02:  lo_idx = 2'd0;
      !lt01 && lt12: lo_idx = 2'd1;
      default:       lo_idx = 2'd2;
    endcase
    unique case (1'b1)
      !lt01 && !lt02: rest_idx = 2'd0;
      lt01 && !lt12:  rest_idx = 2'd1;
      default:        rest_idx = 2'd2;
    endcase
    hi_idx = 2'd3 - lo_idx - rest_idx;
    lo     = pick(lo_idx, n0, n1, n2);
    hi     = pick(hi_idx, n0, n1, n2);
    sum_w  = lo.weight + hi.weight;
  end

endmodule

// File: rtl/huff_enc_core.sv
// Three-symbol Huffman encoder: load, build tree, emit codes.
// HUFF_DONE_FLAG_EN: drive io_out[9] high while parked in DONE.
module huff_enc_core
  import huff_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  huff_enc_core_if.slave io
);

`ifdef HUFF_DONE_FLAG_EN
  localparam logic DONE_FLAG = 1'b1;
`else
  localparam logic DONE_FLAG = 1'b0;
`endif

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0][FREQ_W-1:0] freq_q, freq_d;
  logic [2:0][SYM_W-1:0] sym_q, sym_d;
  logic [1:0] lo_q, lo_d, hi_q, hi_d;
  logic [1:0] rem_q, rem_d;
  logic [WEIGHT_W-1:0] wint_q, wint_d;
  logic rbit_q, rbit_d;
  logic [2:0][CODE_W-1:0] code_q, code_d;
  logic [2:0][CODE_W-1:0] mask_q, mask_d;
  logic [11:0] io_out_q, io_out_d;

  node_t leaf0, leaf1, leaf2;
  node_t rem_n, int_n;
  logic [1:0] m_lo, m_hi, m_rest;
  logic [WEIGHT_W-1:0] m_sum;
  logic [1:0] slot;

  assign leaf0 = {{2'b00, freq_q[0]}, 1'b1, 2'd0};
  assign leaf1 = {{2'b00, freq_q[1]}, 1'b1, 2'd1};
  assign leaf2 = {{2'b00, freq_q[2]}, 1'b1, 2'd2};

  huff_min2 u_min2 (
    .n0       (leaf0),
    .n1       (leaf1),
    .n2       (leaf2),
    .lo_idx   (m_lo),
    .hi_idx   (m_hi),
    .rest_idx (m_rest),
    .sum_w    (m_sum)
  );

  assign rem_n = {{2'b00, freq_q[rem_q]}, 1'b1, rem_q};
  assign int_n = {wint_q, 1'b0, 2'd3};
  assign slot  = cnt_q[2:1];
  assign io.io_out = io_out_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    freq_d   = freq_q;
    sym_d    = sym_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    rem_d    = rem_q;
    wint_d   = wint_q;
    rbit_d   = rbit_q;
    code_d   = code_q;
    mask_d   = mask_q;
    io_out_d = '0;
    unique case (state_q)
      LOAD: begin
        if (io.io_in[11]) begin
          freq_d[cnt_q[1:0]] = io.io_in[10:8];
          sym_d[cnt_q[1:0]]  = io.io_in[7:0];
          if (cnt_q == 3'd2) begin
            cnt_d   = '0;
            state_d = MERGE1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      MERGE1: begin
        lo_d    = m_lo;
        hi_d    = m_hi;
        rem_d   = m_rest;
        wint_d  = m_sum;
        state_d = MERGE2;
      end
      MERGE2: begin
        // Leftover leaf takes branch 1 only if the pair is lighter.
        rbit_d  = node_lt(int_n, rem_n);
        state_d = ASSIGN;
      end
      ASSIGN: begin
        code_d[rem_q] = {2'b00, rbit_q};
        mask_d[rem_q] = 3'b001;
        code_d[lo_q]  = {1'b0, ~rbit_q, 1'b0};
        mask_d[lo_q]  = 3'b011;
        code_d[hi_q]  = {1'b0, ~rbit_q, 1'b1};
        mask_d[hi_q]  = 3'b011;
        cnt_d         = '0;
        state_d       = EMIT;
      end
      EMIT: begin
        if (cnt_q[0]) begin
          io_out_d = {4'b0001, 2'b00,
                      mask_q[slot], code_q[slot]};
        end else begin
          io_out_d = {4'b0001, sym_q[slot]};
        end
        if (cnt_q == 3'd5) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        io_out_d[9] = DONE_FLAG;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      freq_q   <= '0;
      sym_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      rem_q    <= '0;
      wint_q   <= '0;
      rbit_q   <= 1'b0;
      code_q   <= '0;
      mask_q   <= '0;
      io_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      sym_q    <= sym_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      rem_q    <= rem_d;
      wint_q   <= wint_d;
      rbit_q   <= rbit_d;
      code_q   <= code_d;
      mask_q   <= mask_d;
      io_out_q <= io_out_d;
    end
  end

endmodule

// File: tb/tb_huff_enc_core.sv
// Bench for huff_enc_core: directed and random symbol triples
// checked against a sort-based Huffman reference model.
module tb_huff_enc_core;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  huff_enc_core_if bus ();

  huff_enc_core dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

`ifdef HUFF_DONE_FLAG_EN
  localparam logic [11:0] DONE_VAL = 12'h200;
`else
  localparam logic [11:0] DONE_VAL = 12'h000;
`endif

  task automatic chk(input string tag,
                     input logic [11:0] got,
                     input logic [11:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %03h expected %03h",
             tag, got, exp);
    end
  endtask

  // Huffman tree for three leaves: sort by (weight, slot),
  // pair the two lightest, then hang the pair and the
  // heaviest leaf off the root.
  task automatic model(input logic [7:0] s [3],
                       input logic [2:0] f [3],
                       output logic [11:0] wd [6]);
    int ord [3];
    int code [3];
    int mask [3];
    int a, b, c, wi, cb, t;
    for (int i = 0; i < 3; i++) ord[i] = i;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 2; i++)
        if (f[ord[i]] * 4 + ord[i] > f[ord[i+1]] * 4 + ord[i+1]) begin
          t = ord[i]; ord[i] = ord[i+1]; ord[i+1] = t;
        end
    a = ord[0]; b = ord[1]; c = ord[2];
    wi = f[a] + f[b];
    cb = (f[c] <= wi) ? 0 : 1;
    code[c] = cb;           mask[c] = 1;
    code[a] = (1 - cb) * 2; mask[a] = 3;
    code[b] = (1 - cb) * 2 + 1; mask[b] = 3;
    for (int i = 0; i < 3; i++) begin
      wd[2*i]   = 12'h100 | {4'h0, s[i]};
      wd[2*i+1] = 12'h100 | 12'(mask[i] * 8 + code[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.io_in = '0;
    reset = 1'b0;
    #1 chk("reset", bus.io_out, 12'h000);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_case(input string tag,
                          input logic [7:0] s [3],
                          input logic [2:0] f [3],
                          input int gap,
                          input bit hold,
                          input int abort_k);
    logic [11:0] wd [6];
    logic [11:0] exp;
    model(s, f, wd);
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk({tag, "_load"}, bus.io_out, 12'h000);
        bus.io_in = {1'b0, 11'($urandom)};
      end
      @(negedge clk);
      chk({tag, "_load"}, bus.io_out, 12'h000);
      bus.io_in = {1'b1, f[i], s[i]};
    end
    @(negedge clk);
    bus.io_in = hold ? {1'b1, 11'($urandom)} : 12'h000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 4 && k <= 9) exp = wd[k-4];
      else if (k >= 10) exp = DONE_VAL;
      else exp = 12'h000;
      chk($sformatf("%s_e%0d", tag, k), bus.io_out, exp);
      if (k == abort_k) begin
        #2 reset = 1'b0;
        bus.io_in = '0;
        #1 chk({tag, "_abort"}, bus.io_out, 12'h000);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] s [3];
    logic [2:0] f [3];
    bus.io_in = '0;
    do_reset();

    s = '{8'h61, 8'h6E, 8'h6D}; f = '{3'd3, 3'd3, 3'd2};
    run_case("anm", s, f, 0, 1'b0, 0);
    do_reset();

    s = '{8'h41, 8'h42, 8'h43}; f = '{3'd1, 3'd1, 3'd1};
    run_case("abc", s, f, 0, 1'b0, 0);
    do_reset();

    s = '{8'h61, 8'h6E, 8'h6D}; f = '{3'd3, 3'd3, 3'd2};
    run_case("hold", s, f, 0, 1'b1, 0);
    do_reset();

    run_case("gaps", s, f, 3, 1'b0, 0);
    do_reset();

    s = '{8'h00, 8'hFF, 8'h80}; f = '{3'd0, 3'd0, 3'd0};
    run_case("zero", s, f, 1, 1'b0, 0);
    do_reset();

    s = '{8'h11, 8'h22, 8'h33}; f = '{3'd7, 3'd1, 3'd5};
    run_case("abrt", s, f, 0, 1'b1, 6);
    s = '{8'h44, 8'h55, 8'h66}; f = '{3'd2, 3'd7, 3'd7};
    run_case("fresh", s, f, 0, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      do_reset();
      for (int i = 0; i < 3; i++) begin
        s[i] = 8'($urandom);
        f[i] = 3'($urandom_range(0, 7));
      end
      run_case($sformatf("rnd%0d", n), s, f,
               int'($urandom_range(0, 2)),
               1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
